usb_cmd_decode: RTL

Host-to-device command decoder for the RAM tracer: the downstream counterpart of the trace-packet stream. Consumes the received USB byte stream from the FIFO interface, frames it into 4-byte command packets, and drives the runtime configuration (`trace_enable`, `trace_reads`, `turbo`), a timestamp-clear pulse and an echo/sync request back toward the packet transmitter. Sits between `usb_comm`'s receive side and the tracing state machine / `osc_sim`.

---
 rtl/usb_cmd_decode.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/usb_cmd_decode.sv
// Host-to-device command decoder for the RAM tracer.
// Frames the received USB byte stream into 4-byte command packets
// (header with bit7=1, then three body bytes with bit7=0). Executes
// SET_CONFIG, TS_CLEAR and ECHO, and counts framing/protocol errors.
//
// state  | meaning
// S_IDLE | waiting for a header byte
// S_B1   | header latched, expecting body byte 1 (P[20:14])
// S_B2   | expecting body byte 2 (P[13:7])
// S_B3   | expecting body byte 3 (P[6:0]); accepting it executes the command
module usb_cmd_decode #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd48000,
  parameter logic [2:0]  RESET_CONFIG   = 3'b011
) (
  input  logic        i_mclk,
  input  logic        i_reset,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic        o_rx_ready,
  output logic        o_trace_enable,
  output logic        o_trace_reads,
  output logic        o_turbo,
  output logic        o_ts_clear,
  output logic        o_echo_valid,
  output logic [24:0] o_echo_data,
  input  logic        i_echo_ready,
  output logic [7:0]  o_err_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_B1   = 2'd1,
    S_B2   = 2'd2,
    S_B3   = 2'd3
  } state_t;

  localparam logic [2:0] OP_NOP        = 3'd0;
  localparam logic [2:0] OP_SET_CONFIG = 3'd1;
  localparam logic [2:0] OP_TS_CLEAR   = 3'd2;
  localparam logic [2:0] OP_ECHO       = 3'd3;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [2:0]  r_opcode;
  logic [24:0] r_param;
  logic [15:0] r_tmo_cnt;
  logic [2:0]  r_config;
  logic        r_ts_clear;
  logic        r_echo_valid;
  logic [24:0] r_echo_data;
  logic [7:0]  r_err_count;

  logic        w_accept;
  logic        w_is_hdr;
  logic        w_timeout;
  logic        w_load_hdr;
  logic        w_load_b1;
  logic        w_load_b2;
  logic        w_exec;
  logic        w_err;
  logic [24:0] w_param_full;

  // Byte handshake; the whole receive path stalls while an echo is pending.
  assign w_accept     = i_rx_valid && !r_echo_valid;
  assign w_is_hdr     = i_rx_data[7];
  assign w_param_full = {r_param[24:7], i_rx_data[6:0]};
  // Down-counter reaches terminal count after TIMEOUT_CYCLES idle cycles;
  // a byte accepted on that same edge takes priority.
  assign w_timeout    = (r_state != S_IDLE) && !w_accept && !r_echo_valid
                        && (r_tmo_cnt == 16'd0);

  // Next-state and per-byte control decode.
  always_comb begin
    w_state_nxt = r_state;
    w_load_hdr  = 1'b0;
    w_load_b1   = 1'b0;
    w_load_b2   = 1'b0;
    w_exec      = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_is_hdr) begin
            w_load_hdr  = 1'b1;
            w_state_nxt = S_B1;
          end else begin
            w_err = 1'b1;
          end
        end
      end
      S_B1, S_B2, S_B3: begin
        if (w_accept) begin
          if (w_is_hdr) begin
            // Resync: drop the partial packet, treat this byte as a new header.
            w_err       = 1'b1;
            w_load_hdr  = 1'b1;
            w_state_nxt = S_B1;
          end else if (r_state == S_B1) begin
            w_load_b1   = 1'b1;
            w_state_nxt = S_B2;
          end else if (r_state == S_B2) begin
            w_load_b2   = 1'b1;
            w_state_nxt = S_B3;
          end else begin
            w_exec      = 1'b1;
            w_err       = r_opcode[2];
            w_state_nxt = S_IDLE;
          end
        end else if (w_timeout) begin
          w_err       = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_mclk or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Opcode and parameter capture as header/body bytes arrive.
  always_ff @(posedge i_mclk or posedge i_reset) begin
    if (i_reset) begin
      r_opcode <= OP_NOP;
      r_param  <= 25'd0;
    end else begin
      if (w_load_hdr) begin
        r_opcode       <= i_rx_data[6:4];
        r_param[24:21] <= i_rx_data[3:0];
      end
      if (w_load_b1) r_param[20:14] <= i_rx_data[6:0];
      if (w_load_b2) r_param[13:7]  <= i_rx_data[6:0];
    end
  end

  // Inter-byte timeout: reload on every accepted byte, hold while stalled,
  // parked at zero whenever no packet is in progress.
  always_ff @(posedge i_mclk or posedge i_reset) begin
    if (i_reset) begin
      r_tmo_cnt <= 16'd0;
    end else if (w_state_nxt == S_IDLE) begin
      r_tmo_cnt <= 16'd0;
    end else if (w_accept) begin
      r_tmo_cnt <= TIMEOUT_CYCLES - 16'd1;
    end else if (!r_echo_valid && (r_tmo_cnt != 16'd0)) begin
      r_tmo_cnt <= r_tmo_cnt - 16'd1;
    end
  end

  // Command execution: config, timestamp-clear pulse and echo request.
  always_ff @(posedge i_mclk or posedge i_reset) begin
    if (i_reset) begin
      r_config     <= RESET_CONFIG;
      r_ts_clear   <= 1'b0;
      r_echo_valid <= 1'b0;
      r_echo_data  <= 25'd0;
    end else begin
      r_ts_clear <= w_exec && (r_opcode == OP_TS_CLEAR);
      if (w_exec && (r_opcode == OP_SET_CONFIG)) r_config <= w_param_full[2:0];
      if (w_exec && (r_opcode == OP_ECHO)) begin
        r_echo_valid <= 1'b1;
        r_echo_data  <= w_param_full;
      end else if (r_echo_valid && i_echo_ready) begin
        r_echo_valid <= 1'b0;
      end
    end
  end

  // Saturating error counter; at most one error event exists per cycle.
  always_ff @(posedge i_mclk or posedge i_reset) begin
    if (i_reset)                            r_err_count <= 8'd0;
    else if (w_err && (r_err_count != 8'hFF)) r_err_count <= r_err_count + 8'd1;
  end

  assign o_rx_ready     = !r_echo_valid;
  assign o_trace_enable = r_config[0];
  assign o_trace_reads  = r_config[1];
  assign o_turbo        = r_config[2];
  assign o_ts_clear     = r_ts_clear;
  assign o_echo_valid   = r_echo_valid;
  assign o_echo_data    = r_echo_data;
  assign o_err_count    = r_err_count;

endmodule
